lane_stripe_deskew: RTL and testbench

Parametrised successor to the two-lane distributer in the logical layer. On transmit, it stripes the transport byte stream round-robin across `LANES` lanes. On receive, it deskews up to `LANES` lanes against a per-lane alignment marker using per-lane FIFOs, then merges them back into a single ordered byte stream. It sits between the data bus and the encoding/decoding blocks on `fsm_clk`.

---
 rtl/lane_stripe_deskew.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_lane_stripe_deskew.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_stripe_deskew.sv
// lane_stripe_deskew: stripes a byte stream round-robin across LANES lanes (TX) and deskews/merges
// LANES lanes back into one ordered stream (RX). Define LANE_STRIPE_SKEW_MON_EN to add the skew_o monitor port.
module lane_stripe_deskew #(
    parameter int LANES      = 2,
    parameter int DATA_W     = 8,
    parameter int SKEW_DEPTH = 4
) (
    input  logic                    fsm_clk,
    input  logic                    rst,
    input  logic                    enable_t,
    input  logic [DATA_W-1:0]       tx_data_i,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    output logic [LANES*DATA_W-1:0] lane_tx_o,
    output logic                    lane_tx_valid_o,
    input  logic                    enable_r,
    input  logic [LANES*DATA_W-1:0] lane_rx_i,
    input  logic [LANES-1:0]        lane_rx_valid_i,
    input  logic [LANES-1:0]        lane_rx_sync_i,
    output logic [DATA_W-1:0]       rx_data_o,
    output logic                    rx_valid_o,
    output logic                    deskew_done_o,
    output logic                    deskew_err_o
`ifdef LANE_STRIPE_SKEW_MON_EN
    ,
    output logic [$clog2(SKEW_DEPTH+1)-1:0] skew_o
`endif
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = $clog2(SKEW_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = $clog2(SKEW_DEPTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0] SKEW_MAX = CNT_W'(SKEW_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LOCKED,
        ST_ERROR
    } rx_state_e;

    // ------------------------------------------------------------------
    // TX striping
    // ------------------------------------------------------------------
    logic [LANES-1:0][DATA_W-1:0] stage_q, stage_d;
    logic [IDX_W-1:0]             tx_idx_q, tx_idx_d;
    logic [LANES*DATA_W-1:0]      lane_tx_q, lane_tx_d;
    logic                         lane_tx_valid_q, lane_tx_valid_d;
    logic                         tx_fire;

    assign tx_ready_o      = enable_t;
    assign tx_fire         = tx_valid_i & enable_t;
    assign lane_tx_o       = lane_tx_q;
    assign lane_tx_valid_o = lane_tx_valid_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stage_d         = stage_q;
        tx_idx_d        = tx_idx_q;
        lane_tx_d       = lane_tx_q;
        lane_tx_valid_d = 1'b0;
        if (!enable_t) begin
            tx_idx_d = '0;
        end else if (tx_fire) begin
            stage_d[tx_idx_q] = tx_data_i;
            if (tx_idx_q == LAST_IDX) begin
                lane_tx_d       = stage_d;
                lane_tx_valid_d = 1'b1;
                tx_idx_d        = '0;
            end else begin
                tx_idx_d = tx_idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; blocking is reserved for always_comb.
    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            stage_q         <= '0;
            tx_idx_q        <= '0;
            lane_tx_q       <= '0;
            lane_tx_valid_q <= 1'b0;
        end else begin
            stage_q         <= stage_d;
            tx_idx_q        <= tx_idx_d;
            lane_tx_q       <= lane_tx_d;
            lane_tx_valid_q <= lane_tx_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // RX deskew
    // ------------------------------------------------------------------
    rx_state_e state_q, state_d;
    logic      done_q, done_d, err_q, err_d;

    logic [DATA_W-1:0]            fifo_mem_q [LANES][SKEW_DEPTH];
    logic [LANES-1:0][PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LANES-1:0][DATA_W-1:0] rx_lane, fifo_head;
    logic [LANES-1:0]             fifo_empty, fifo_full, wr_en;
    logic [LANES-1:0]             synced_q, synced_d, sync_hit, data_strb, synced_now;
    logic [CNT_W-1:0]             cnt_q, cnt_d, skew_now;
    logic                         any_synced_q, all_synced, timeout, overflow, pop;

    logic [LANES-1:0][DATA_W-1:0] sh_word_q, sh_word_d;
    logic [IDX_W-1:0]             sh_idx_q, sh_idx_d;
    logic                         sh_active_q, sh_active_d, sh_last;

    assign rx_lane   = lane_rx_i;
    assign sync_hit  = lane_rx_valid_i & lane_rx_sync_i;
    assign data_strb = lane_rx_valid_i & ~lane_rx_sync_i;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            fifo_empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            fifo_full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                            (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
            fifo_head[k]  = fifo_mem_q[k][rd_ptr_q[k][AW-1:0]];
        end
    end

    // A lane only stores data once its own marker has been seen; the marker byte itself never enters a FIFO.
    always_comb begin
        wr_en = '0;
        if (state_q == ST_ALIGN) begin
            wr_en = data_strb & synced_q;
        end else if (state_q == ST_LOCKED) begin
            wr_en = data_strb;
        end
    end

    assign sh_last      = sh_active_q && (sh_idx_q == LAST_IDX);
    assign pop          = (state_q == ST_LOCKED) && (fifo_empty == '0) && (!sh_active_q || sh_last);
    assign overflow     = |(wr_en & fifo_full & ~{LANES{pop}});
    assign synced_now   = synced_q | sync_hit;
    assign all_synced   = &synced_now;
    assign any_synced_q = |synced_q;
    assign skew_now     = any_synced_q ? cnt_q : '0;
    assign timeout      = any_synced_q && (cnt_q >= SKEW_MAX);

    // FSM: state register
    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!enable_r) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_ALIGN;
                ST_ALIGN: begin
                    if (overflow) begin
                        state_d = ST_ERROR;
                    end else if (all_synced && (skew_now < SKEW_MAX)) begin
                        state_d = ST_LOCKED;
                    end else if (timeout) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_LOCKED: if (overflow) state_d = ST_ERROR;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs, registered alongside the state so the flags never glitch
    always_comb begin
        done_d = (state_d == ST_LOCKED);
        err_d  = (state_d == ST_ERROR);
    end

    assign deskew_done_o = done_q;
    assign deskew_err_o  = err_q;

    always_comb begin
        synced_d    = synced_q;
        cnt_d       = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sh_word_d   = sh_word_q;
        sh_idx_d    = sh_idx_q;
        sh_active_d = sh_active_q;

        if (state_q == ST_ALIGN) begin
            synced_d = synced_now;
            if ((state_d == ST_ALIGN) && (any_synced_q || (|sync_hit))) begin
                cnt_d = skew_now + CNT_W'(1);
            end
        end

        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
            if (pop)      rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
        end

        if (pop) begin
            sh_word_d   = fifo_head;
            sh_idx_d    = '0;
            sh_active_d = 1'b1;
        end else if (sh_active_q) begin
            if (sh_last) begin
                sh_idx_d    = '0;
                sh_active_d = 1'b0;
            end else begin
                sh_idx_d = sh_idx_q + IDX_W'(1);
            end
        end

        if (state_d != ST_LOCKED) begin
            sh_idx_d    = '0;
            sh_active_d = 1'b0;
        end
        if (state_d == ST_IDLE) begin
            synced_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            synced_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sh_word_q   <= '0;
            sh_idx_q    <= '0;
            sh_active_q <= 1'b0;
        end else begin
            synced_q    <= synced_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sh_word_q   <= sh_word_d;
            sh_idx_q    <= sh_idx_d;
            sh_active_q <= sh_active_d;
        end
    end

    // NOTE: FIFO storage is not reset; pointers define validity, so stale contents are never read.
    always_ff @(posedge fsm_clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                fifo_mem_q[k][wr_ptr_q[k][AW-1:0]] <= rx_lane[k];
            end
        end
    end

    assign rx_valid_o = sh_active_q;
    assign rx_data_o  = sh_active_q ? sh_word_q[sh_idx_q] : '0;

`ifdef LANE_STRIPE_SKEW_MON_EN
    logic [CNT_W-1:0] skew_q, skew_d;

    always_comb begin
        skew_d = skew_q;
        if ((state_q == ST_ALIGN) && (state_d == ST_LOCKED)) begin
            skew_d = skew_now;
        end
        if (state_d == ST_IDLE) begin
            skew_d = '0;
        end
    end

    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            skew_q <= '0;
        end else begin
            skew_q <= skew_d;
        end
    end

    assign skew_o = skew_q;
`endif

endmodule

// File: tb/tb_lane_stripe_deskew.sv
// Directed self-checking bench for lane_stripe_deskew: a LANES=2 and a LANES=4 instance share clock and reset.
module tb_lane_stripe_deskew;

    logic fsm_clk;
    logic rst;

    // LANES=2 instance signals
    logic        enable_t_2, tx_valid_2, tx_ready_2, lane_tx_valid_2;
    logic [7:0]  tx_data_2;
    logic [15:0] lane_tx_2;
    logic        enable_r_2;
    logic [15:0] lane_rx_2;
    logic [1:0]  lane_rx_valid_2, lane_rx_sync_2;
    logic [7:0]  rx_data_2;
    logic        rx_valid_2, done_2, err_2;

    // LANES=4 instance signals
    logic        enable_t_4, tx_valid_4, tx_ready_4, lane_tx_valid_4;
    logic [7:0]  tx_data_4;
    logic [31:0] lane_tx_4;
    logic        enable_r_4;
    logic [31:0] lane_rx_4;
    logic [3:0]  lane_rx_valid_4, lane_rx_sync_4;
    logic [7:0]  rx_data_4;
    logic        rx_valid_4, done_4, err_4;

`ifdef LANE_STRIPE_SKEW_MON_EN
    logic [2:0]  skew_2, skew_4;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] rxq[$];
    int         rx_cyc[$];

    lane_stripe_deskew #(.LANES(2), .DATA_W(8), .SKEW_DEPTH(4)) u_dut2 (
        .fsm_clk        (fsm_clk),
        .rst            (rst),
        .enable_t       (enable_t_2),
        .tx_data_i      (tx_data_2),
        .tx_valid_i     (tx_valid_2),
        .tx_ready_o     (tx_ready_2),
        .lane_tx_o      (lane_tx_2),
        .lane_tx_valid_o(lane_tx_valid_2),
        .enable_r       (enable_r_2),
        .lane_rx_i      (lane_rx_2),
        .lane_rx_valid_i(lane_rx_valid_2),
        .lane_rx_sync_i (lane_rx_sync_2),
        .rx_data_o      (rx_data_2),
        .rx_valid_o     (rx_valid_2),
        .deskew_done_o  (done_2),
        .deskew_err_o   (err_2)
`ifdef LANE_STRIPE_SKEW_MON_EN
        ,
        .skew_o         (skew_2)
`endif
    );

    lane_stripe_deskew #(.LANES(4), .DATA_W(8), .SKEW_DEPTH(4)) u_dut4 (
        .fsm_clk        (fsm_clk),
        .rst            (rst),
        .enable_t       (enable_t_4),
        .tx_data_i      (tx_data_4),
        .tx_valid_i     (tx_valid_4),
        .tx_ready_o     (tx_ready_4),
        .lane_tx_o      (lane_tx_4),
        .lane_tx_valid_o(lane_tx_valid_4),
        .enable_r       (enable_r_4),
        .lane_rx_i      (lane_rx_4),
        .lane_rx_valid_i(lane_rx_valid_4),
        .lane_rx_sync_i (lane_rx_sync_4),
        .rx_data_o      (rx_data_4),
        .rx_valid_o     (rx_valid_4),
        .deskew_done_o  (done_4),
        .deskew_err_o   (err_4)
`ifdef LANE_STRIPE_SKEW_MON_EN
        ,
        .skew_o         (skew_4)
`endif
    );

    initial fsm_clk = 1'b0;
    always #5 fsm_clk = ~fsm_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fsm_clk);
        #1;
    endtask

    // Drive one cycle of LANES=2 RX input, then record any merged byte that appears.
    task automatic step2(input logic [1:0] v, input logic [1:0] s, input logic [15:0] d);
        lane_rx_valid_2 = v;
        lane_rx_sync_2  = s;
        lane_rx_2       = d;
        tick();
        cyc++;
        if (rx_valid_2) begin
            rxq.push_back(rx_data_2);
            rx_cyc.push_back(cyc);
        end
        lane_rx_valid_2 = '0;
        lane_rx_sync_2  = '0;
        lane_rx_2       = '0;
    endtask

    initial begin
        rst = 1'b0;
        enable_t_2 = 0; tx_valid_2 = 0; tx_data_2 = '0;
        enable_r_2 = 0; lane_rx_2 = '0; lane_rx_valid_2 = '0; lane_rx_sync_2 = '0;
        enable_t_4 = 0; tx_valid_4 = 0; tx_data_4 = '0;
        enable_r_4 = 0; lane_rx_4 = '0; lane_rx_valid_4 = '0; lane_rx_sync_4 = '0;

        repeat (3) tick();
        check("rst_lane_tx", lane_tx_2, 16'h0);
        check("rst_lane_tx_valid", lane_tx_valid_2, 0);
        check("rst_rx_valid", rx_valid_2, 0);
        check("rst_rx_data", rx_data_2, 0);
        check("rst_done", done_2, 0);
        check("rst_err", err_2, 0);
`ifdef LANE_STRIPE_SKEW_MON_EN
        check("rst_skew", skew_2, 0);
`endif
        rst = 1'b1;
        tick();

        // ---------------- TX striping, LANES=2 ----------------
        enable_t_2 = 1; tx_valid_2 = 1;
        check("tx_ready", tx_ready_2, 1);
        tx_data_2 = 8'hA0; tick();
        check("tx_partial_valid", lane_tx_valid_2, 0);
        tx_data_2 = 8'hA1; tick();
        check("tx_w0_valid", lane_tx_valid_2, 1);
        check("tx_w0_data", lane_tx_2, 16'hA1A0);
        tx_data_2 = 8'hA2; tick();
        check("tx_w0_pulse", lane_tx_valid_2, 0);
        check("tx_w0_hold", lane_tx_2, 16'hA1A0);
        tx_data_2 = 8'hA3; tick();
        check("tx_w1_valid", lane_tx_valid_2, 1);
        check("tx_w1_data", lane_tx_2, 16'hA3A2);
        tx_valid_2 = 0; tick();
        check("tx_idle_valid", lane_tx_valid_2, 0);

        // enable_t low discards a partial word
        tx_valid_2 = 1; tx_data_2 = 8'hB0; tick();
        enable_t_2 = 0; tx_valid_2 = 0;
        check("tx_ready_off", tx_ready_2, 0);
        tick();
        enable_t_2 = 1; tx_valid_2 = 1;
        tx_data_2 = 8'hC0; tick();
        check("tx_discard_partial", lane_tx_valid_2, 0);
        tx_data_2 = 8'hC1; tick();
        check("tx_after_disable", lane_tx_2, 16'hC1C0);

        // reset mid-word: outputs clear at once, staging index restarts at lane 0
        tx_data_2 = 8'hD0; tick();
        tx_valid_2 = 0;
        #2 rst = 1'b0;
        #1;
        check("tx_rst_data", lane_tx_2, 16'h0);
        check("tx_rst_valid", lane_tx_valid_2, 0);
        #2 rst = 1'b1;
        tick();
        tx_valid_2 = 1;
        tx_data_2 = 8'hE0; tick();
        tx_data_2 = 8'hE1; tick();
        check("tx_post_rst_valid", lane_tx_valid_2, 1);
        check("tx_post_rst_data", lane_tx_2, 16'hE1E0);
        tx_valid_2 = 0; enable_t_2 = 0;
        tick();

        // ---------------- RX, LANES=4, zero skew ----------------
        enable_r_4 = 1; tick();
        check("rx4_align_done", done_4, 0);
        lane_rx_valid_4 = 4'hF; lane_rx_sync_4 = 4'hF; tick();
        check("rx4_lock_done", done_4, 1);
        check("rx4_lock_err", err_4, 0);
`ifdef LANE_STRIPE_SKEW_MON_EN
        check("rx4_skew", skew_4, 0);
`endif
        lane_rx_sync_4 = 4'h0; lane_rx_4 = 32'h13121110; tick();
        lane_rx_valid_4 = 4'h0; lane_rx_4 = '0;
        check("rx4_pop_latency", rx_valid_4, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rx4_valid_%0d", k), rx_valid_4, 1);
            check($sformatf("rx4_data_%0d", k), rx_data_4, 32'h10 + k);
        end
        tick();
        check("rx4_drain", rx_valid_4, 0);
        enable_r_4 = 0; tick();

        // ---------------- RX, LANES=2, lane 1 three cycles late ----------------
        enable_r_2 = 1; tick();
        rxq.delete(); rx_cyc.delete(); cyc = 0;
        step2(2'b01, 2'b01, 16'h0000);
        step2(2'b01, 2'b00, 16'h0020);
        step2(2'b00, 2'b00, 16'h0000);
        check("skew3_pre_done", done_2, 0);
        step2(2'b11, 2'b10, 16'h0022);
        check("skew3_done", done_2, 1);
        check("skew3_err", err_2, 0);
`ifdef LANE_STRIPE_SKEW_MON_EN
        check("skew3_skew", skew_2, 3);
`endif
        step2(2'b10, 2'b00, 16'h2100);
        step2(2'b00, 2'b00, 16'h0000);
        step2(2'b10, 2'b00, 16'h2300);
        repeat (4) step2(2'b00, 2'b00, 16'h0000);
        check("skew3_count", rxq.size(), 4);
        while (rxq.size() < 4) begin
            rxq.push_back(8'hxx);
            rx_cyc.push_back(-100);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("skew3_byte_%0d", k), rxq[k], 32'h20 + k);
        end
        check("skew3_no_bubble", rx_cyc[3] - rx_cyc[0], 3);
        check("skew3_first_cycle", rx_cyc[0], 6);
        enable_r_2 = 0; tick();
        check("idle_done", done_2, 0);
`ifdef LANE_STRIPE_SKEW_MON_EN
        check("idle_skew", skew_2, 0);
`endif

        // ---------------- RX, LANES=2, lane 1 four cycles late -> ERROR ----------------
        enable_r_2 = 1; tick();
        rxq.delete(); rx_cyc.delete(); cyc = 0;
        step2(2'b01, 2'b01, 16'h0000);
        step2(2'b01, 2'b00, 16'h0030);
        step2(2'b00, 2'b00, 16'h0000);
        step2(2'b00, 2'b00, 16'h0000);
        check("skew4_pre_err", err_2, 0);
        step2(2'b10, 2'b10, 16'h0000);
        check("skew4_err", err_2, 1);
        check("skew4_done", done_2, 0);
        step2(2'b10, 2'b00, 16'h3100);
        repeat (3) step2(2'b00, 2'b00, 16'h0000);
        check("skew4_err_held", err_2, 1);
        check("skew4_no_output", rxq.size(), 0);
        enable_r_2 = 0; tick();

        // ---------------- LOCKED overflow ----------------
        enable_r_2 = 1; tick();
        rxq.delete(); rx_cyc.delete();
        step2(2'b11, 2'b11, 16'h0000);
        check("ovf_locked", done_2, 1);
        for (int i = 0; i < 4; i++) begin
            step2(2'b01, 2'b00, 16'h0040 + 16'(i));
        end
        check("ovf_full_no_err", err_2, 0);
        step2(2'b01, 2'b00, 16'h0044);
        check("ovf_err", err_2, 1);
        check("ovf_done_clear", done_2, 0);
        check("ovf_no_output", rxq.size(), 0);
        enable_r_2 = 0; tick();
        check("ovf_idle_err", err_2, 0);
        enable_r_2 = 1; tick();
        step2(2'b11, 2'b11, 16'h0000);
        check("ovf_realign_done", done_2, 1);

        // ---------------- reset mid RX stream ----------------
        step2(2'b11, 2'b00, 16'h5150);
        step2(2'b00, 2'b00, 16'h0000);
        check("rxrst_pre_valid", rx_valid_2, 1);
        check("rxrst_pre_data", rx_data_2, 8'h50);
        #2 rst = 1'b0;
        #1;
        check("rxrst_valid", rx_valid_2, 0);
        check("rxrst_data", rx_data_2, 0);
        check("rxrst_done", done_2, 0);
        #2 rst = 1'b1;
        tick();
        rxq.delete(); rx_cyc.delete();
        step2(2'b11, 2'b00, 16'h6160);
        step2(2'b00, 2'b00, 16'h0000);
        step2(2'b00, 2'b00, 16'h0000);
        check("rxrst_needs_sync", done_2, 0);
        check("rxrst_no_output", rxq.size(), 0);
        step2(2'b11, 2'b11, 16'h0000);
        check("rxrst_resync_done", done_2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
